// File: rtl/v_hier_qmon.sv
// v_hier_qmon
//   Watches the hierarchy sub-block's output vector (qvec). The vector is
//   brought into the clk domain through a two-stage synchroniser. Every bit
//   change becomes an event tagged with a free-running timestamp and a
//   per-bit rise mask. Events are queued in a small FIFO and drained to a
//   valid/ready sink. Events that arrive while the FIFO is full are dropped
//   and counted in a saturating counter.
//
// Ports
//   clk        rising-edge clock
//   reset_l    asynchronous active-low reset
//   qvec       monitored vector (may be asynchronous to clk)
//   enable     event capture enable; the change detector keeps tracking when low
//   out_valid  FIFO head entry valid
//   out_ready  sink accepts the head entry
//   out_vec    synchronised vector value at the event (0 when idle)
//   out_rise   bits that went 0->1 at the event (0 when idle)
//   out_ts     timestamp of the event (0 when idle)
//   level      current FIFO occupancy
//   ovf_count  dropped-event count, saturating at 255, cleared only by reset
module v_hier_qmon #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int TSW   = 8
) (
  input  logic                     clk,
  input  logic                     reset_l,
  input  logic [WIDTH-1:0]         qvec,
  input  logic                     enable,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_vec,
  output logic [WIDTH-1:0]         out_rise,
  output logic [TSW-1:0]           out_ts,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               ovf_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] sync1, sync2, prev;
  logic [WIDTH-1:0] cur, rise;
  logic             change;
  logic [TSW-1:0]   ts;

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [PW-1:0]    wptr, rptr;

  logic [WIDTH-1:0] mem_vec  [DEPTH];
  logic [WIDTH-1:0] mem_rise [DEPTH];
  logic [TSW-1:0]   mem_ts   [DEPTH];

  logic push_req, pop, full, do_push, ovf;

  always_comb begin
    cur      = sync2;
    change   = (cur != prev);
    rise     = cur & ~prev;
    push_req = enable & change;
    level    = wptr - rptr;
    out_valid = (level != '0);
    full     = (level == PW'(DEPTH));
    pop      = out_valid & out_ready;
    // A pop on a full FIFO frees the slot the same edge, so the push lands.
    do_push  = push_req & (~full | pop);
    ovf      = push_req & full & ~pop;
  end

  always_comb begin
    out_vec  = '0;
    out_rise = '0;
    out_ts   = '0;
    if (out_valid) begin
      out_vec  = mem_vec[rptr[AW-1:0]];
      out_rise = mem_rise[rptr[AW-1:0]];
      out_ts   = mem_ts[rptr[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      sync1     <= '0;
      sync2     <= '0;
      prev      <= '0;
      ts        <= '0;
      wptr      <= '0;
      rptr      <= '0;
      ovf_count <= '0;
    end else begin
      sync1 <= qvec;
      sync2 <= sync1;
      prev  <= sync2;
      ts    <= ts + TSW'(1);
      if (do_push) wptr <= wptr + PW'(1);
      if (pop)     rptr <= rptr + PW'(1);
      if (ovf && (ovf_count != '1)) ovf_count <= ovf_count + 8'd1;
    end
  end

  // Storage needs no reset: entries are only visible between rptr and wptr.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_vec[wptr[AW-1:0]]  <= cur;
      mem_rise[wptr[AW-1:0]] <= rise;
      mem_ts[wptr[AW-1:0]]   <= ts;
    end
  end

endmodule

// File: tb/tb_v_hier_qmon.sv
module tb_v_hier_qmon;

  logic       clk = 1'b0;
  logic       reset_l = 1'b0;
  logic [3:0] qvec = '0;
  logic       enable = 1'b1;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [3:0] out_vec, out_rise;
  logic [7:0] out_ts;
  logic [2:0] level;
  logic [7:0] ovf_count;

  v_hier_qmon #(.WIDTH(4), .DEPTH(4), .TSW(8)) dut (
    .clk(clk), .reset_l(reset_l), .qvec(qvec), .enable(enable),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
    .out_rise(out_rise), .out_ts(out_ts), .level(level), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] vec;
    logic [3:0] rise;
    logic [7:0] ts;
  } ent_t;

  ent_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;          // edges since reset release == DUT ts before that edge
  logic [3:0] model_q = '0;

  always @(posedge clk) begin
    if (!reset_l) cyc = 0;
    else cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a new qvec value. It is captured at the next edge and pushed two
  // edges later, carrying the ts of that pushing edge.
  task automatic set_q(input logic [3:0] v, input bit queued);
    ent_t e;
    e.vec  = v;
    e.rise = v & ~model_q;
    e.ts   = 8'((cyc + 2) % 256);
    if (queued) sb.push_back(e);
    model_q = v;
    qvec = v;
  endtask

  // Monitor: one comparison set per accepted entry, idle outputs must be zero.
  always @(negedge clk) begin
    if (reset_l === 1'b1) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_entry: got vec=%b rise=%b ts=%0d expected none",
                   out_vec, out_rise, out_ts);
        end else begin
          ent_t e;
          e = sb.pop_front();
          check("out_vec",  32'(out_vec),  32'(e.vec));
          check("out_rise", 32'(out_rise), 32'(e.rise));
          check("out_ts",   32'(out_ts),   32'(e.ts));
        end
      end else if (out_valid === 1'b0) begin
        check("idle_zero", 32'({out_vec, out_rise, out_ts}), 32'd0);
      end
    end
  end

  initial begin
    // Reset state
    reset_l = 1'b0; qvec = '0; enable = 1'b1; out_ready = 1'b0;
    tick(3);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_level", 32'(level), 0);
    check("rst_ovf",   32'(ovf_count), 0);

    // First event: qvec changes just before the first edge after release
    reset_l = 1'b1;
    model_q = '0;
    set_q(4'b0101, 1);
    tick(2);
    check("lat_before", 32'(out_valid), 0);
    tick(1);
    check("lat_after", 32'(out_valid), 1);
    check("lat_level", 32'(level), 1);
    out_ready = 1'b1; tick(1); out_ready = 1'b0;
    tick(1);
    check("drain1_level", 32'(level), 0);

    // Fill with out_ready low; fifth change overflows
    set_q(4'b0100, 1); tick(3);
    set_q(4'b0110, 1); tick(3);
    set_q(4'b1110, 1); tick(3);
    set_q(4'b1111, 1); tick(3);
    set_q(4'b0000, 0); tick(3);
    check("full_level", 32'(level), 4);
    check("ovf_one", 32'(ovf_count), 1);
    out_ready = 1'b1; tick(5); out_ready = 1'b0;
    check("drain2_level", 32'(level), 0);

    // Full FIFO: pop and push on the same edge
    set_q(4'b0001, 1); tick(3);
    set_q(4'b0011, 1); tick(3);
    set_q(4'b0111, 1); tick(3);
    set_q(4'b1111, 1); tick(3);
    check("full2_level", 32'(level), 4);
    set_q(4'b1110, 1);
    tick(2);
    out_ready = 1'b1; tick(1); out_ready = 1'b0;
    check("popush_level", 32'(level), 4);
    check("popush_ovf", 32'(ovf_count), 1);
    out_ready = 1'b1; tick(5); out_ready = 1'b0;
    check("drain3_level", 32'(level), 0);

    // Enable low: changes are not queued, no stale event on re-enable
    enable = 1'b0;
    set_q(4'b0001, 0); tick(1);
    set_q(4'b1010, 0); tick(2);
    set_q(4'b0110, 0); tick(3);
    enable = 1'b1;
    tick(4);
    check("dis_level", 32'(level), 0);

    // Saturating overflow count
    set_q(4'b0111, 1); tick(3);
    set_q(4'b1111, 1); tick(3);
    set_q(4'b1011, 1); tick(3);
    set_q(4'b1001, 1); tick(3);
    for (int i = 0; i < 300; i++) begin
      set_q((i % 2 == 0) ? 4'b0000 : 4'b1001, 0);
      tick(1);
    end
    tick(3);
    check("sat_level", 32'(level), 4);
    check("sat_ovf", 32'(ovf_count), 255);

    // Asynchronous reset mid-cycle
    @(posedge clk); #3;
    reset_l = 1'b0;
    qvec = '0;
    #1;
    check("arst_valid", 32'(out_valid), 0);
    check("arst_level", 32'(level), 0);
    check("arst_ovf",   32'(ovf_count), 0);
    sb.delete();
    model_q = '0;
    tick(2);

    // Timestamp wrap while an entry is stalled
    reset_l = 1'b1;
    tick(248);
    set_q(4'b0001, 1);           // ts 250
    tick(3);
    tick(260);
    set_q(4'b0011, 1);           // ts (513 % 256) = 1
    tick(3);
    check("wrap_level", 32'(level), 2);
    out_ready = 1'b1; tick(3); out_ready = 1'b0;
    check("wrap_drain", 32'(level), 0);

    tick(2);
    check("sb_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/v_hier_qmon.md
Name: v_hier_qmon

Overview:
- Downstream consumer of the hierarchy sub-block's 4-bit output vector (qvec).
- Synchronises the vector into the local clock domain and detects any bit change.
- Queues each change event, tagged with a timestamp and per-bit rise mask, in a small FIFO.
- Drains the FIFO to a valid/ready sink; counts events dropped on overflow.

Parameters:
- WIDTH, 4, width of monitored vector.
- DEPTH, 4, FIFO entries; power of 2, min 2.
- TSW, 8, timestamp counter width.

Ports:
- clk  input  1  rising-edge clock.
- reset_l  input  1  asynchronous active-low reset.
- qvec  input  WIDTH  monitored vector; may be asynchronous to clk.
- enable  input  1  event capture enable.
- out_valid  output  1  FIFO head entry valid.
- out_ready  input  1  sink accepts head entry.
- out_vec  output  WIDTH  synchronised vector value at the event.
- out_rise  output  WIDTH  bits that went 0->1 at the event.
- out_ts  output  TSW  timestamp of the event.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- ovf_count  output  8  dropped-event count, saturating.

Behaviour:
- Reset is asynchronous on reset_l low. Release is synchronous to clk, handled upstream.
- While reset_l is low, these are all 0:
  - sync1, sync2, prev registers
  - timestamp counter ts
  - FIFO read/write pointers
  - out_valid, level, ovf_count
- Synchronizer:
  - sync1 <= qvec; sync2 <= sync1; prev <= sync2, every cycle regardless of enable.
  - Internal signals: cur = sync2; change = (cur != prev); rise = cur & ~prev.
- Timestamp: ts increments by 1 every cycle and wraps from 2^TSW-1 to 0. No saturation.
- Push:
  - push_req = enable & change.
  - On that edge, write entry {ts, cur, rise}, where ts is the pre-edge value.
- Latency:
  - qvec settles before edge E0; sync1 captures at E0, sync2 at E1; push occurs at E2.
  - out_valid rises after E2 if the FIFO was empty: 3 edges from qvec settle to visibility.
- Pop: on an edge where out_valid & out_ready, the head advances.
- Outputs:
  - out_vec, out_rise and out_ts are driven from the head entry when out_valid=1.
  - They are forced to 0 when out_valid=0.
- FIFO storage:
  - Read/write pointers are $clog2(DEPTH)+1 bits each; the extra MSB resolves full vs empty.
  - level = wptr - rptr.
  - out_valid = (level != 0).
- Push and pop on the same edge:
  - When empty: push enters the FIFO, pop is ignored because out_valid=0. Entry appears the next cycle; no bypass.
  - When full: pop frees the slot and the push is accepted. level stays DEPTH; no overflow.
  - Otherwise: both take effect and level is unchanged.
- Overflow:
  - Condition: push_req while level==DEPTH and no pop on that edge.
  - The entry is dropped and FIFO contents are unchanged.
  - ovf_count increments, saturating at 255.
  - ovf_count clears only on reset.
- Enable low:
  - Changes are not queued.
  - prev still tracks, so re-enabling does not report stale changes.
  - Pops continue normally.
- Reset mid-operation: all queued entries are discarded; outputs return to reset values immediately (asynchronously).
- Non-zero qvec at reset release with enable=1: produces one event (cur != prev=0) once sync2 loads the value.
- Multi-bit change within one cycle: produces exactly one event carrying all changed bits.
- A qvec pulse shorter than one clk period: may be missed. This is permitted.

Test Plan:
- Reset, enable=1, qvec 0->4'b0101 stable -> out_valid=1 after 3rd edge; out_vec=0101, out_rise=0101; out_ts = pushing-edge ts (2 if qvec changed just before the first edge after release).
- With out_ready=0: qvec 0101->0100->0110->1110->1111->0000 (each held 3 cycles) -> 4 entries, level=4; 5th change dropped, ovf_count=1; then out_ready=1 drains 0100,0110,1110,1111 in order with out_rise 0000,0010,1000,0001.
- FIFO full, out_ready=1 and a change on the same edge -> no overflow, level stays 4, new entry appears last in order.
- enable=0, toggle qvec several times, then enable=1 with qvec stable -> no entries, level=0.
- Hold FIFO full, issue 300 changes -> ovf_count saturates at 255; assert reset_l=0 mid-clock -> out_valid, level, ovf_count go 0 without a clock edge.
- Stall a queued entry across 2^TSW cycles and push a second event after ts wraps -> second out_ts is smaller than the first; both delivered intact.
